// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the mem_responder slice.
//   state_t          : responder FSM states
//   MMIO_ADDR        : full 16-bit address decoded as the switch/display port
//   ADDR_W_DEF       : default storage word-address width
//   WAIT_CYCLES_DEF  : default wait states added to every access
//   WAIT_CNT_W       : width of the wait-state down-counter
package mem_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int WAIT_CNT_W      = 4;

  localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array -- single-port word storage, 2^ADDR_W x 16.
// Synchronous write, combinational read, no reset (contents survive reset).
// Ports:
//   i_clk   : system clock, rising edge
//   i_we    : write enable for this edge
//   i_addr  : word address (shared by read and write)
//   i_wdata : write data
//   o_rdata : read data at i_addr, combinational
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic [15:0]       o_rdata
);

  logic [15:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder -- wait-state memory responder for a simple CPU datapath.
// Accepts one read or write per CE assertion, adds WAIT_CYCLES wait states,
// pulses R for one cycle when the access completes, then waits for CE to
// drop before accepting another request.
//
// Optional feature: define MEM_RESPONDER_MMIO_EN to decode address 16'hFFFF
// as an I/O port (reads return SW, writes load HEX_REG). Without it, that
// address is ordinary (aliased) storage and HEX_REG is held at zero.
//
// Ports:
//   Clk           : system clock, rising edge
//   Reset_al      : asynchronous active-low reset
//   MEM_CE        : access request enable
//   MEM_OE        : read strobe
//   MEM_WE        : write strobe (wins over MEM_OE)
//   ADDR          : word address
//   Data_from_CPU : write data
//   SW            : switch inputs (MMIO read source)
//   Data_to_CPU   : read data, held until the next completed read
//   R             : one-cycle ready pulse
//   HEX_REG       : display register (MMIO write target)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for CE with OE or WE; request latched on leaving
// ACCESS  | counting down wait states; CE low aborts back to IDLE
// DONE    | access committed on entry; R high for this one cycle
// RELEASE | access complete; hold until CE drops so it is not repeated
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset_al,
  input  logic        MEM_CE,
  input  logic        MEM_OE,
  input  logic        MEM_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] SW,
  output logic [15:0] Data_to_CPU,
  output logic        R,
  output logic [15:0] HEX_REG
);

  // ACCESS exits when the counter has reached zero, so it is loaded with
  // one less than the number of wait states.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
  logic                  w_enter_done;

  logic [ADDR_W-1:0]     r_addr;
  logic [15:0]           r_wdata;
  logic                  r_is_wr;
  logic                  r_is_mmio;
  logic [15:0]           r_data_to_cpu;

  logic                  w_req;
  logic                  w_mmio_live;
  logic [ADDR_W-1:0]     w_cur_addr;
  logic [15:0]           w_cur_wdata;
  logic                  w_cur_wr;
  logic                  w_cur_mmio;
  logic                  w_mem_we;
  logic [15:0]           w_mem_rdata;

  assign w_req = MEM_CE & (MEM_OE | MEM_WE);

`ifdef MEM_RESPONDER_MMIO_EN
  assign w_mmio_live = (ADDR == MMIO_ADDR);
`else
  assign w_mmio_live = 1'b0;
  logic w_unused_addr;
  assign w_unused_addr = ^ADDR;
`endif

  // With zero wait states DONE is entered on the request edge itself, before
  // the latches hold anything, so the live inputs are used in IDLE.
  assign w_cur_addr  = (r_state == IDLE) ? ADDR[ADDR_W-1:0] : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? Data_from_CPU    : r_wdata;
  assign w_cur_wr    = (r_state == IDLE) ? MEM_WE           : r_is_wr;
  assign w_cur_mmio  = (r_state == IDLE) ? w_mmio_live      : r_is_mmio;

  assign w_mem_we = w_enter_done & w_cur_wr & ~w_cur_mmio;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_enter_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_wait_cnt_nxt = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!MEM_CE) begin
          w_state_nxt = IDLE;
        end else if (r_wait_cnt == '0) begin
          w_state_nxt  = DONE;
          w_enter_done = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!MEM_CE) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_wr   <= 1'b0;
      r_is_mmio <= 1'b0;
    end else if ((r_state == IDLE) && w_req) begin
      r_addr    <= ADDR[ADDR_W-1:0];
      r_wdata   <= Data_from_CPU;
      r_is_wr   <= MEM_WE;
      r_is_mmio <= w_mmio_live;
    end
  end

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      r_data_to_cpu <= 16'h0000;
    end else if (w_enter_done && !w_cur_wr) begin
      r_data_to_cpu <= w_cur_mmio ? SW : w_mem_rdata;
    end
  end

`ifdef MEM_RESPONDER_MMIO_EN
  logic [15:0] r_hex;

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      r_hex <= 16'h0000;
    end else if (w_enter_done && w_cur_wr && w_cur_mmio) begin
      r_hex <= w_cur_wdata;
    end
  end

  assign HEX_REG = r_hex;
`else
  assign HEX_REG = 16'h0000;
`endif

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .i_clk   (Clk),
    .i_we    (w_mem_we),
    .i_addr  (w_cur_addr),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_mem_rdata)
  );

  assign Data_to_CPU = r_data_to_cpu;
  assign R           = (r_state == DONE);

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- directed bench for mem_responder.
// Two instances share stimulus: u_dut_w2 (WAIT_CYCLES=2) and u_dut_w0
// (WAIT_CYCLES=0). Define MEM_RESPONDER_MMIO_EN for both RTL and bench to
// cover the I/O port variant.
module tb_mem_responder;
  import mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_al = 1'b0;
  logic        MEM_CE = 1'b0;
  logic        MEM_OE = 1'b0;
  logic        MEM_WE = 1'b0;
  logic [15:0] ADDR = '0;
  logic [15:0] Data_from_CPU = '0;
  logic [15:0] SW = '0;

  logic [15:0] d2, d0, h2, h0;
  logic        r2, r0;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut_w2 (
    .Clk(Clk), .Reset_al(Reset_al), .MEM_CE(MEM_CE), .MEM_OE(MEM_OE),
    .MEM_WE(MEM_WE), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .SW(SW),
    .Data_to_CPU(d2), .R(r2), .HEX_REG(h2)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .Clk(Clk), .Reset_al(Reset_al), .MEM_CE(MEM_CE), .MEM_OE(MEM_OE),
    .MEM_WE(MEM_WE), .ADDR(ADDR), .Data_from_CPU(Data_from_CPU), .SW(SW),
    .Data_to_CPU(d0), .R(r0), .HEX_REG(h0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request, scramble address/data after the request edge, hold
  // for 'hold' cycles recording R latency and pulse count, then drop CE.
  task automatic access(input logic oe, input logic we, input logic [15:0] a,
                        input logic [15:0] d, input int hold,
                        output int lat2, output int lat0,
                        output int np2, output int np0);
    MEM_CE = 1'b1; MEM_OE = oe; MEM_WE = we; ADDR = a; Data_from_CPU = d;
    lat2 = 0; lat0 = 0; np2 = 0; np0 = 0;
    for (int i = 1; i <= hold; i++) begin
      @(posedge Clk); #1;
      if (i == 1) begin
        ADDR = ~a;
        Data_from_CPU = ~d;
      end
      if (r2) begin np2++; if (lat2 == 0) lat2 = i; end
      if (r0) begin np0++; if (lat0 == 0) lat0 = i; end
    end
    @(negedge Clk);
    MEM_CE = 1'b0; MEM_OE = 1'b0; MEM_WE = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_wr(input string tag, input logic oe, input logic [15:0] a, input logic [15:0] d);
    int l2, l0, n2, n0;
    access(oe, 1'b1, a, d, 6, l2, l0, n2, n0);
    check({tag, " lat W2"}, l2, 3);
    check({tag, " lat W0"}, l0, 1);
    check({tag, " pulses W2"}, n2, 1);
    check({tag, " pulses W0"}, n0, 1);
  endtask

  task automatic do_rd(input string tag, input logic [15:0] a, input logic [15:0] e2, input logic [15:0] e0);
    int l2, l0, n2, n0;
    access(1'b1, 1'b0, a, 16'h0000, 6, l2, l0, n2, n0);
    check({tag, " lat W2"}, l2, 3);
    check({tag, " lat W0"}, l0, 1);
    check({tag, " data W2"}, d2, e2);
    check({tag, " data W0"}, d0, e0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n2, n0;

    repeat (2) @(negedge Clk);
    check("reset R", {r2, r0}, 0);
    check("reset data", {d2, d0}, 0);
    check("reset hex", {h2, h0}, 0);
    check("reset state", u_dut_w2.r_state, IDLE);

    // request presented right as reset releases: taken on the first edge
    Reset_al = 1'b1;
    do_wr("wr BEEF", 1'b0, 16'h0012, 16'hBEEF);
    check("data after write", {d2, d0}, 0);
    do_rd("rd 0012", 16'h0012, 16'hBEEF, 16'hBEEF);

    // held request: one completion only, parked in RELEASE
    MEM_CE = 1'b1; MEM_WE = 1'b1; ADDR = 16'h0030; Data_from_CPU = 16'h3030;
    n2 = 0; n0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      n2 += int'(r2);
      n0 += int'(r0);
    end
    check("held pulses W2", n2, 1);
    check("held pulses W0", n0, 1);
    check("held state W2", u_dut_w2.r_state, RELEASE);
    check("held state W0", u_dut_w0.r_state, RELEASE);
    @(negedge Clk); MEM_CE = 1'b0; MEM_WE = 1'b0;
    @(negedge Clk);
    do_rd("rd 0030", 16'h0030, 16'h3030, 16'h3030);

    // abort: CE dropped one cycle into ACCESS
    do_wr("wr 5555", 1'b0, 16'h0005, 16'h5555);
    MEM_CE = 1'b1; MEM_WE = 1'b1; ADDR = 16'h0005; Data_from_CPU = 16'h1234;
    @(negedge Clk); MEM_CE = 1'b0; MEM_WE = 1'b0;
    n2 = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      n2 += int'(r2);
    end
    check("abort pulses W2", n2, 0);
    check("abort data hold W2", d2, 16'h3030);
    @(negedge Clk);
    // the zero-wait instance completed its write on the request edge
    do_rd("rd 0005 after abort", 16'h0005, 16'h5555, 16'h1234);

    // reset during ACCESS
    MEM_CE = 1'b1; MEM_WE = 1'b1; ADDR = 16'h0012; Data_from_CPU = 16'hDEAD;
    @(posedge Clk); #1;
    check("pre-reset state W2", u_dut_w2.r_state, ACCESS);
    Reset_al = 1'b0;
    #1;
    check("async reset R", {r2, r0}, 0);
    check("async reset data", {d2, d0}, 0);
    check("async reset hex", {h2, h0}, 0);
    @(negedge Clk); MEM_CE = 1'b0; MEM_WE = 1'b0; Reset_al = 1'b1;
    @(negedge Clk);
    do_rd("rd 0012 after reset", 16'h0012, 16'hBEEF, 16'hDEAD);

    // aliasing on the low ADDR_W bits
    do_wr("wr alias", 1'b0, 16'h0103, 16'h7777);
    do_rd("rd alias", 16'h0003, 16'h7777, 16'h7777);

    // OE and WE together behave as a write
    do_wr("wr oe+we", 1'b1, 16'h0020, 16'h4321);
    check("data after oe+we W2", d2, 16'h7777);
    check("data after oe+we W0", d0, 16'h7777);
    do_rd("rd 0020", 16'h0020, 16'h4321, 16'h4321);

    do_wr("wr 00FF", 1'b0, 16'h00FF, 16'h1111);
    SW = 16'h00A5;
`ifdef MEM_RESPONDER_MMIO_EN
    do_rd("rd mmio", 16'hFFFF, 16'h00A5, 16'h00A5);
    do_wr("wr mmio", 1'b0, 16'hFFFF, 16'h0042);
    check("hex W2", h2, 16'h0042);
    check("hex W0", h0, 16'h0042);
    do_rd("rd 00FF", 16'h00FF, 16'h1111, 16'h1111);
`else
    do_rd("rd FFFF alias", 16'hFFFF, 16'h1111, 16'h1111);
    do_wr("wr FFFF", 1'b0, 16'hFFFF, 16'h0042);
    check("hex W2", h2, 16'h0000);
    check("hex W0", h0, 16'h0000);
    do_rd("rd 00FF", 16'h00FF, 16'h0042, 16'h0042);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the word-address width of internal storage (depth 2^ADDR_W x 16).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the added wait states per access (legal range 0..15).
REQ-003 SHALL have port Clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 SHALL have port Reset_al, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port MEM_CE, input, 1 bit: access-request enable from the CPU datapath.
REQ-006 SHALL have port MEM_OE, input, 1 bit: read strobe.
REQ-007 SHALL have port MEM_WE, input, 1 bit: write strobe.
REQ-008 SHALL have port ADDR, input, 16 bits: word address from MAR.
REQ-009 SHALL have port Data_from_CPU, input, 16 bits: write data from MDR.
REQ-010 SHALL have port SW, input, 16 bits: switch inputs.
REQ-011 SHALL have port Data_to_CPU, output, 16 bits: read data toward MDR_In.
REQ-012 SHALL have port R, output, 1 bit: memory-ready pulse.
REQ-013 SHALL have port HEX_REG, output, 16 bits: display register.

Function
REQ-014 SHALL implement the states IDLE, ACCESS, DONE and RELEASE.
REQ-015 In IDLE, a request is MEM_CE=1 and (MEM_OE=1 or MEM_WE=1). The first sampling edge latches ADDR, Data_from_CPU and op, then moves to ACCESS, or to DONE directly if WAIT_CYCLES=0.
REQ-016 ACCESS SHALL count down WAIT_CYCLES cycles, then move to DONE.
REQ-017 R SHALL be 1 for exactly one cycle, in DONE only. It rises WAIT_CYCLES+1 cycles after the request edge.
REQ-018 DONE SHALL always move to RELEASE. RELEASE SHALL hold until MEM_CE=0, then return to IDLE, so a held request completes exactly once.
REQ-019 A write SHALL commit the latched data to the latched address on the edge that enters DONE.
REQ-020 A read SHALL update Data_to_CPU on the edge that enters DONE. Data_to_CPU SHALL hold its value until the next read completes; writes leave it unchanged.
REQ-021 If MEM_OE=1 and MEM_WE=1 together, the access SHALL be treated as a write.
REQ-022 If MEM_CE drops during ACCESS, the access SHALL abort to IDLE with no write, no R pulse and Data_to_CPU unchanged.
REQ-023 Inputs changing after the request edge SHALL be ignored; only the latched values are used.
REQ-024 Storage index SHALL be ADDR[ADDR_W-1:0]. Upper address bits are ignored, so aliasing is expected.
REQ-025 The wait counter SHALL be 4 bits and SHALL reload on every new request.

Reset
REQ-026 Reset_al=0 SHALL asynchronously force state IDLE, R=0, Data_to_CPU=16'h0000, HEX_REG=16'h0000 and the wait counter to 0.
REQ-027 Reset mid-access SHALL discard the access; no write occurs.
REQ-028 Storage contents SHALL NOT be reset.
REQ-029 The first request SHALL be accepted on the first rising edge after Reset_al deasserts.

Configuration
REQ-030 SHALL honour macro MEM_RESPONDER_MMIO_EN.
- Defined: full address 16'hFFFF bypasses storage. A read returns SW, sampled at DONE entry. A write loads HEX_REG and leaves storage untouched. Timing and handshake are identical to a storage access.
- Undefined: 16'hFFFF is an ordinary aliased storage address, HEX_REG is tied to 16'h0000, and SW is unused.

Structure
REQ-031 Package mem_pkg SHALL hold:
- the state enum;
- MMIO_ADDR = 16'hFFFF;
- the default ADDR_W and WAIT_CYCLES values;
- the WAIT counter width.
REQ-032 Storage SHALL be sub-module mem_array: single-port, synchronous write, combinational read, 2^ADDR_W x 16.
REQ-033 mem_responder SHALL own the FSM, the latches and MMIO decode.

Verification
REQ-034 Write then read: write 16'hBEEF to 16'h0012 with WAIT_CYCLES=2, drop CE, then read 16'h0012. R SHALL pulse 3 cycles after each request edge, and Data_to_CPU SHALL equal 16'hBEEF.
REQ-035 Held request: hold MEM_CE=1 and MEM_WE=1 for 10 cycles. Exactly one R pulse SHALL occur and the state SHALL remain RELEASE until CE=0.
REQ-036 Abort: start a write of 16'h1234 to 16'h0005, then drop CE after 1 cycle. No R pulse SHALL occur, and a later read of 16'h0005 SHALL return its prior value.
REQ-037 Reset mid-access: assert Reset_al=0 during ACCESS. R, Data_to_CPU and HEX_REG SHALL be 0 immediately, without waiting for a clock edge.
REQ-038 MMIO, with MEM_RESPONDER_MMIO_EN defined: set SW=16'h00A5 and read 16'hFFFF, which SHALL return 16'h00A5. Write 16'h0042 to 16'hFFFF, which SHALL give HEX_REG=16'h0042.
REQ-039 Aliasing and zero wait: with WAIT_CYCLES=0, write 16'h7777 to 16'h0103, then read 16'h0003. The read SHALL return 16'h7777, and R SHALL pulse 1 cycle after each request edge.
